// File: rtl/hero_life_ctl_if.sv
// rtl/hero_life_ctl_if.sv - game-progress handshake bundle between environment and hero_life_ctl
interface hero_life_ctl_if;
  logic       start;
  logic       player_collision;
  logic       goal_reached;
  logic [1:0] lives;
  logic [3:0] level;
  logic [2:0] state_code;
  logic       freeze;
  logic       invuln;
  logic       hero_respawn;
  logic       level_load;

  modport master (
    output start, player_collision, goal_reached,
    input  lives, level, state_code, freeze, invuln, hero_respawn, level_load
  );

  modport slave (
    input  start, player_collision, goal_reached,
    output lives, level, state_code, freeze, invuln, hero_respawn, level_load
  );
endinterface

// File: rtl/hero_life_ctl.sv
// rtl/hero_life_ctl.sv - lives, level, respawn and freeze sequencing for the game tick
module hero_life_ctl #(
  parameter int LIVES        = 3,
  parameter int RESPAWN_TIME = 60,
  parameter int INVULN_TIME  = 120,
  parameter int LEVEL_TIME   = 90,
  parameter int LEVELS       = 4
) (
  input  logic           clk,
  input  logic           rst,
  hero_life_ctl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_PLAY       = 3'd1,
    S_HIT        = 3'd2,
    S_INVULN     = 3'd3,
    S_LEVEL_DONE = 3'd4,
    S_GAME_OVER  = 3'd5,
    S_WIN        = 3'd6
  } state_t;

  localparam logic [1:0] LIVES_INIT  = 2'(LIVES);
  localparam logic [3:0] LAST_LEVEL  = 4'(LEVELS - 1);
  localparam logic [7:0] HIT_LAST    = 8'(RESPAWN_TIME - 1);
  localparam logic [7:0] INVULN_LAST = 8'(INVULN_TIME - 1);
  localparam logic [7:0] LEVEL_LAST  = 8'(LEVEL_TIME - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic [1:0] r_lives;
  logic [1:0] w_lives_nxt;
  logic [3:0] r_level;
  logic [3:0] w_level_nxt;
  logic       r_freeze;
  logic       w_freeze_nxt;
  logic       r_invuln;
  logic       w_invuln_nxt;
  logic       r_respawn;
  logic       w_respawn_nxt;
  logic       r_load;
  logic       w_load_nxt;
  logic       r_start_q;
  logic       w_start_re;

  assign w_start_re = bus.start & ~r_start_q;

  // Next-state, next-counter and next-output decode for the game-progress FSM
  always_comb begin
    w_state_nxt   = r_state;
    w_lives_nxt   = r_lives;
    w_level_nxt   = r_level;
    w_respawn_nxt = 1'b0;
    w_load_nxt    = 1'b0;

    case (r_state)
      S_IDLE, S_GAME_OVER, S_WIN: begin
        if (w_start_re) begin
          w_state_nxt   = S_PLAY;
          w_lives_nxt   = LIVES_INIT;
          w_level_nxt   = 4'd0;
          w_load_nxt    = 1'b1;
          w_respawn_nxt = 1'b1;
        end
      end
      S_PLAY: begin
        // Goal wins over a simultaneous hit
        if (bus.goal_reached) begin
          w_state_nxt = S_LEVEL_DONE;
        end else if (bus.player_collision) begin
          if (r_lives <= 2'd1) begin
            w_lives_nxt = 2'd0;
            w_state_nxt = S_GAME_OVER;
          end else begin
            w_lives_nxt = r_lives - 2'd1;
            w_state_nxt = S_HIT;
          end
        end
      end
      S_HIT: begin
        if (r_cnt == HIT_LAST) begin
          w_state_nxt   = S_INVULN;
          w_respawn_nxt = 1'b1;
        end
      end
      S_INVULN: begin
        if (bus.goal_reached) begin
          w_state_nxt = S_LEVEL_DONE;
        end else if (r_cnt == INVULN_LAST) begin
          w_state_nxt = S_PLAY;
        end
      end
      S_LEVEL_DONE: begin
        if (r_cnt == LEVEL_LAST) begin
          if (r_level >= LAST_LEVEL) begin
            w_state_nxt = S_WIN;
          end else begin
            w_level_nxt   = r_level + 4'd1;
            w_state_nxt   = S_PLAY;
            w_load_nxt    = 1'b1;
            w_respawn_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Counter restarts from zero on every state entry
    w_cnt_nxt    = (w_state_nxt != r_state) ? 8'd0 : r_cnt + 8'd1;
    w_freeze_nxt = (w_state_nxt != S_PLAY) && (w_state_nxt != S_INVULN);
    w_invuln_nxt = (w_state_nxt == S_INVULN);
  end

  // State, counter and registered outputs; reset drops any pending pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 8'd0;
      r_lives   <= LIVES_INIT;
      r_level   <= 4'd0;
      r_freeze  <= 1'b1;
      r_invuln  <= 1'b0;
      r_respawn <= 1'b0;
      r_load    <= 1'b0;
      r_start_q <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_lives   <= w_lives_nxt;
      r_level   <= w_level_nxt;
      r_freeze  <= w_freeze_nxt;
      r_invuln  <= w_invuln_nxt;
      r_respawn <= w_respawn_nxt;
      r_load    <= w_load_nxt;
      r_start_q <= bus.start;
    end
  end

  assign bus.lives        = r_lives;
  assign bus.level        = r_level;
  assign bus.state_code   = r_state;
  assign bus.freeze       = r_freeze;
  assign bus.invuln       = r_invuln;
  assign bus.hero_respawn = r_respawn;
  assign bus.level_load   = r_load;

endmodule

// File: tb/tb_hero_life_ctl.sv
// tb/tb_hero_life_ctl.sv - self-checking bench for hero_life_ctl with a timer-countdown model
module tb_hero_life_ctl;

  localparam int LIVES        = 3;
  localparam int RESPAWN_TIME = 60;
  localparam int INVULN_TIME  = 120;
  localparam int LEVEL_TIME   = 90;
  localparam int LEVELS       = 4;

  localparam int M_IDLE = 0, M_PLAY = 1, M_HIT = 2, M_INVULN = 3;
  localparam int M_DONE = 4, M_OVER = 5, M_WIN = 6;

  logic clk = 1'b0;
  logic rst;
  hero_life_ctl_if bus();

  hero_life_ctl #(
    .LIVES(LIVES), .RESPAWN_TIME(RESPAWN_TIME), .INVULN_TIME(INVULN_TIME),
    .LEVEL_TIME(LEVEL_TIME), .LEVELS(LEVELS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_on  = 1'b0;

  // Model: game mode plus cycles left in the current timed phase
  int m_mode  = M_IDLE;
  int m_left  = 0;
  int m_lives = LIVES;
  int m_level = 0;
  bit m_prev  = 1'b0;
  bit m_resp  = 1'b0;
  bit m_load  = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic cyc(input bit s, input bit pc, input bit gr, input bit r);
    bus.start            = s;
    bus.player_collision = pc;
    bus.goal_reached     = gr;
    rst                  = r;
    @(posedge clk);
    #1;
  endtask

  // Stay in state st until it changes; n = extra cycles spent after the current one
  task automatic hold(input int st, input bit rnd_pc, output int n);
    bit done;
    n    = 0;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      cyc(1'b0, rnd_pc ? 1'($urandom_range(1)) : 1'b0, 1'b0, 1'b0);
      if (int'(bus.state_code) == st) n++;
      else done = 1'b1;
    end
    if (!done) chk("hold_timeout", 0, 1);
  endtask

  // Reference model advanced on every clock edge from the sampled inputs
  always @(posedge clk) begin : model
    int mode, left, lives, level;
    bit resp, load, sre;
    mode = m_mode; left = m_left; lives = m_lives; level = m_level;
    resp = 1'b0; load = 1'b0;
    if (rst) begin
      mode = M_IDLE; left = 0; lives = LIVES; level = 0;
      m_prev <= 1'b0;
    end else begin
      sre = bus.start && !m_prev;
      m_prev <= bus.start;
      if (mode == M_IDLE || mode == M_OVER || mode == M_WIN) begin
        if (sre) begin
          mode = M_PLAY; lives = LIVES; level = 0; load = 1'b1; resp = 1'b1;
        end
      end else if (mode == M_PLAY) begin
        if (bus.goal_reached) begin
          mode = M_DONE; left = LEVEL_TIME;
        end else if (bus.player_collision) begin
          lives = lives - 1;
          if (lives == 0) mode = M_OVER;
          else begin mode = M_HIT; left = RESPAWN_TIME; end
        end
      end else if (mode == M_HIT) begin
        left--;
        if (left == 0) begin mode = M_INVULN; left = INVULN_TIME; resp = 1'b1; end
      end else if (mode == M_INVULN) begin
        if (bus.goal_reached) begin
          mode = M_DONE; left = LEVEL_TIME;
        end else begin
          left--;
          if (left == 0) mode = M_PLAY;
        end
      end else if (mode == M_DONE) begin
        left--;
        if (left == 0) begin
          if (level == LEVELS - 1) mode = M_WIN;
          else begin level++; mode = M_PLAY; load = 1'b1; resp = 1'b1; end
        end
      end
    end
    m_mode <= mode; m_left <= left; m_lives <= lives; m_level <= level;
    m_resp <= resp; m_load <= load;
  end

  // Every-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("lives", int'(bus.lives), m_lives);
      chk("level", int'(bus.level), m_level);
      chk("state_code", int'(bus.state_code), m_mode);
      chk("freeze", int'(bus.freeze), (m_mode == M_PLAY || m_mode == M_INVULN) ? 0 : 1);
      chk("invuln", int'(bus.invuln), (m_mode == M_INVULN) ? 1 : 0);
      chk("hero_respawn", int'(bus.hero_respawn), int'(m_resp));
      chk("level_load", int'(bus.level_load), int'(m_load));
    end
  end

  initial begin
    int n;
    int pulses;
    bit s_cur;

    bus.start = 1'b0; bus.player_collision = 1'b0; bus.goal_reached = 1'b0; rst = 1'b1;

    cyc(0, 0, 0, 1);
    cmp_on = 1'b1;
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    chk("rst_state", int'(bus.state_code), 0);
    chk("rst_lives", int'(bus.lives), 3);
    chk("rst_freeze", int'(bus.freeze), 1);

    cyc(1, 0, 0, 0);
    chk("start_state", int'(bus.state_code), 1);
    chk("start_load", int'(bus.level_load), 1);
    chk("start_respawn", int'(bus.hero_respawn), 1);
    chk("start_freeze", int'(bus.freeze), 0);
    cyc(0, 0, 0, 0);
    chk("load_width", int'(bus.level_load), 0);

    cyc(0, 1, 0, 0);
    chk("hit1_lives", int'(bus.lives), 2);
    chk("hit1_state", int'(bus.state_code), 2);
    hold(2, 1'b0, n);
    chk("hit_cycles", n + 1, 60);
    chk("invuln_entry", int'(bus.state_code), 3);
    chk("invuln_respawn", int'(bus.hero_respawn), 1);
    hold(3, 1'b1, n);
    chk("invuln_cycles", n + 1, 120);
    chk("invuln_lives", int'(bus.lives), 2);
    chk("after_invuln", int'(bus.state_code), 1);

    cyc(0, 1, 0, 0);
    chk("hit2_lives", int'(bus.lives), 1);
    hold(2, 1'b0, n);
    hold(3, 1'b0, n);
    cyc(0, 1, 0, 0);
    chk("hit3_lives", int'(bus.lives), 0);
    chk("hit3_state", int'(bus.state_code), 5);
    chk("over_freeze", int'(bus.freeze), 1);

    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1, 0, 0, 0);
      pulses += int'(bus.level_load);
    end
    chk("restart_once", pulses, 1);
    chk("restart_lives", int'(bus.lives), 3);
    cyc(0, 0, 0, 0);

    cyc(0, 1, 1, 0);
    chk("goal_pri_state", int'(bus.state_code), 4);
    chk("goal_pri_lives", int'(bus.lives), 3);
    hold(4, 1'b0, n);
    chk("done_cycles", n + 1, 90);
    chk("level1", int'(bus.level), 1);
    chk("level1_load", int'(bus.level_load), 1);

    for (int lv = 1; lv < 4; lv++) begin
      cyc(0, 0, 1, 0);
      hold(4, 1'b0, n);
    end
    chk("win_state", int'(bus.state_code), 6);
    chk("win_level", int'(bus.level), 3);
    cyc(0, 0, 1, 0);
    chk("win_level_hold", int'(bus.level), 3);

    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 30; i++) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    chk("midrst_state", int'(bus.state_code), 0);
    chk("midrst_lives", int'(bus.lives), 3);
    chk("midrst_freeze", int'(bus.freeze), 1);
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(0, 0, 0, 0);
      pulses += int'(bus.hero_respawn);
    end
    chk("midrst_no_respawn", pulses, 0);
    chk("midrst_idle", int'(bus.state_code), 0);

    s_cur = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(39) == 0) s_cur = ~s_cur;
      cyc(s_cur, ($urandom_range(19) == 0), ($urandom_range(59) == 0), ($urandom_range(2999) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
